// File: rtl/control_pkg.sv
// Shared definitions for the sequenced control unit: FSM state type,
// fixed bus-source / destination indices and IR field extraction helpers.
// The helpers take the IR zero-extended to 32 bits plus the field widths,
// so they serve any DEST_W / SRC_W configuration.
package control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT,
    ST_HALT
  } state_t;

  // Bus source indices (bit positions in assertEn)
  localparam int SRC_ROM = 0;
  localparam int SRC_A   = 2;
  localparam int SRC_RAM = 5;

  // Destination indices (bit positions in loadEn)
  localparam int DEST_PC  = 1;
  localparam int DEST_A   = 2;
  localparam int RAM_DEST = 5;

  // All-ones mask of the given width; an IR equal to it is the HALT opcode
  function automatic logic [31:0] halt_op(input int ir_w);
    return (32'd1 << ir_w) - 32'd1;
  endfunction

  // Source field occupies the low SRC_W bits
  function automatic logic [31:0] field_source(input logic [31:0] ir_word, input int src_w);
    return ir_word & ((32'd1 << src_w) - 32'd1);
  endfunction

  // bitLo sits directly above the source field
  function automatic logic field_bit_lo(input logic [31:0] ir_word, input int src_w);
    return ir_word[src_w];
  endfunction

  // Destination field sits above bitLo
  function automatic logic [31:0] field_dest(input logic [31:0] ir_word, input int src_w,
                                             input int dest_w);
    return (ir_word >> (src_w + 1)) & ((32'd1 << dest_w) - 32'd1);
  endfunction

  // bitHi is the most significant IR bit
  function automatic logic field_bit_hi(input logic [31:0] ir_word, input int src_w,
                                        input int dest_w);
    return ir_word[src_w + dest_w + 1];
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: turns the IR into one-hot load and
// bus-source vectors, flags RAM involvement and evaluates the jump
// condition against the currently latched carry flag.
module control_decode
  import control_pkg::*;
#(
  parameter int DEST_W = 3,
  parameter int SRC_W  = 3
) (
  input  logic [DEST_W+SRC_W+1:0] ir,
  input  logic                    a_is_zero,
  input  logic                    flag_carry,
  output logic [2**DEST_W-1:0]    load_onehot,
  output logic [2**SRC_W-1:0]     src_onehot,
  output logic                    is_ram,
  output logic                    ram_write,
  output logic                    is_halt,
  output logic                    dest_is_a,
  output logic                    dest_is_pc,
  output logic                    bit_lo,
  output logic                    jump_cond
);

  localparam int IR_W = DEST_W + SRC_W + 2;

  logic [31:0] ir_word;
  logic [31:0] dest_idx;
  logic [31:0] src_idx;
  logic        bit_hi;

  // Field extraction and decode; dest 0 (NOP) and the PC never raise a load strobe
  always_comb begin
    ir_word    = 32'(ir);
    dest_idx   = field_dest(ir_word, SRC_W, DEST_W);
    src_idx    = field_source(ir_word, SRC_W);
    bit_lo     = field_bit_lo(ir_word, SRC_W);
    bit_hi     = field_bit_hi(ir_word, SRC_W, DEST_W);
    is_halt    = (ir_word == halt_op(IR_W));
    dest_is_pc = (dest_idx == 32'(DEST_PC));
    dest_is_a  = (dest_idx == 32'(DEST_A));
    ram_write  = (dest_idx == 32'(RAM_DEST));
    is_ram     = ram_write || (src_idx == 32'(SRC_RAM));

    load_onehot = '0;
    if (!dest_is_pc && (dest_idx != 32'd0))
      load_onehot[dest_idx[DEST_W-1:0]] = 1'b1;

    src_onehot = '0;
    src_onehot[src_idx[SRC_W-1:0]] = 1'b1;

    jump_cond = (bit_lo & a_is_zero) | (bit_hi & flag_carry) | (~bit_lo & ~bit_hi);
  end

endmodule

// File: rtl/sequenced_control.sv
// Multi-cycle control sequencer: steps FETCH/EXEC per instruction, stretches
// RAM accesses in WAIT until memReady (with a timeout that raises a sticky
// busError), latches the carry flag and supports a sticky HALT.
// Optional single-step mode is enabled by defining CONTROL_STEP_EN, which
// adds the stepReq port and holds FETCH until a step request is seen.
module sequenced_control
  import control_pkg::*;
#(
  parameter int DEST_W   = 3,
  parameter int SRC_W    = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    resetBar,
  input  logic [DEST_W+SRC_W+1:0] ir,
  input  logic                    aIsZero,
  input  logic                    aluCarry,
  input  logic                    memReady,
  input  logic                    run,
`ifdef CONTROL_STEP_EN
  input  logic                    stepReq,
`endif
  output logic                    loadIR,
  output logic [2**DEST_W-1:0]    loadEn,
  output logic [2**SRC_W-1:0]     assertEn,
  output logic                    storeMem,
  output logic                    doSubtract,
  output logic                    doJump,
  output logic                    flagCarry,
  output logic                    halted,
  output logic                    busError
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t                  state;
  logic [CNT_W-1:0]        wait_count;
  logic                    flag_carry_q;
  logic                    halted_q;
  logic                    bus_error_q;

  logic [2**DEST_W-1:0]    load_onehot;
  logic [2**SRC_W-1:0]     src_onehot;
  logic                    is_ram;
  logic                    ram_write;
  logic                    is_halt;
  logic                    dest_is_a;
  logic                    dest_is_pc;
  logic                    bit_lo;
  logic                    jump_cond;
  logic                    fetch_go;
  logic                    exec_done;
  logic                    wait_done;
  logic                    complete;

  control_decode #(
    .DEST_W (DEST_W),
    .SRC_W  (SRC_W)
  ) u_decode (
    .ir          (ir),
    .a_is_zero   (aIsZero),
    .flag_carry  (flag_carry_q),
    .load_onehot (load_onehot),
    .src_onehot  (src_onehot),
    .is_ram      (is_ram),
    .ram_write   (ram_write),
    .is_halt     (is_halt),
    .dest_is_a   (dest_is_a),
    .dest_is_pc  (dest_is_pc),
    .bit_lo      (bit_lo),
    .jump_cond   (jump_cond)
  );

`ifdef CONTROL_STEP_EN
  assign fetch_go = stepReq;
`else
  assign fetch_go = 1'b1;
`endif

  // Instruction completion: EXEC finishes at once unless a RAM access is still pending
  always_comb begin
    exec_done = (state == ST_EXEC) && !is_halt && !(is_ram && !memReady);
    wait_done = (state == ST_WAIT) && memReady;
    complete  = exec_done || wait_done;
  end

  // Sequencer state, wait counter and sticky flags
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state        <= ST_IDLE;
      wait_count   <= '0;
      flag_carry_q <= 1'b0;
      halted_q     <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (!run)          state <= ST_IDLE;
          else if (fetch_go) state <= ST_EXEC;
        end
        ST_EXEC: begin
          wait_count <= '0;
          if (is_halt) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else if (is_ram && !memReady) begin
            state <= ST_WAIT;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (memReady) begin
            state      <= ST_FETCH;
            wait_count <= '0;
          end else if (wait_count == CNT_W'(WAIT_MAX)) begin
            state       <= ST_HALT;
            wait_count  <= '0;
            bus_error_q <= 1'b1;
            halted_q    <= 1'b1;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (complete && dest_is_a)
        flag_carry_q <= aluCarry;
    end
  end

  // Strobes and enables derived from the registered state and the current IR
  always_comb begin
    loadIR     = 1'b0;
    loadEn     = '0;
    assertEn   = '0;
    storeMem   = 1'b0;
    doSubtract = 1'b0;
    doJump     = 1'b0;
    unique case (state)
      ST_FETCH: begin
        loadIR            = fetch_go;
        assertEn[SRC_ROM] = fetch_go;
      end
      ST_EXEC, ST_WAIT: begin
        if (!is_halt) begin
          assertEn   = src_onehot;
          storeMem   = ram_write;
          doSubtract = bit_lo;
          if (complete) begin
            loadEn = load_onehot;
            doJump = dest_is_pc & jump_cond;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign flagCarry = flag_carry_q;
  assign halted    = halted_q;
  assign busError  = bus_error_q;

endmodule

// File: tb/tb_sequenced_control.sv
// Self-checking bench for sequenced_control: reset state, a table of
// single-cycle instructions with hand-computed outputs, hand-written RAM
// wait / timeout / halt / reset sequences, and randomized instructions
// checked against an instruction-level reference model.
module tb_sequenced_control;

  logic       clk = 1'b0;
  logic       resetBar;
  logic [7:0] ir;
  logic       aIsZero;
  logic       aluCarry;
  logic       memReady;
  logic       run;
`ifdef CONTROL_STEP_EN
  logic       stepReq;
`endif
  logic       loadIR;
  logic [7:0] loadEn;
  logic [7:0] assertEn;
  logic       storeMem;
  logic       doSubtract;
  logic       doJump;
  logic       flagCarry;
  logic       halted;
  logic       busError;

  logic [19:0] strobes;
  assign strobes = {loadIR, loadEn, assertEn, storeMem, doSubtract, doJump};

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [7:0] ir;
    logic       az;
    logic       carry;
    logic [7:0] load_en;
    logic [7:0] assert_en;
    logic       store;
    logic       jump;
    logic       sub;
  } vec_t;

  vec_t vecs[15];

  sequenced_control dut (
    .clk        (clk),
    .resetBar   (resetBar),
    .ir         (ir),
    .aIsZero    (aIsZero),
    .aluCarry   (aluCarry),
    .memReady   (memReady),
    .run        (run),
`ifdef CONTROL_STEP_EN
    .stepReq    (stepReq),
`endif
    .loadIR     (loadIR),
    .loadEn     (loadEn),
    .assertEn   (assertEn),
    .storeMem   (storeMem),
    .doSubtract (doSubtract),
    .doJump     (doJump),
    .flagCarry  (flagCarry),
    .halted     (halted),
    .busError   (busError)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] ir_v, input logic mr, input logic az,
                               input logic cy);
    ir       = ir_v;
    memReady = mr;
    aIsZero  = az;
    aluCarry = cy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    resetBar = 1'b0;
    #1;
    checkOutput("reset_strobes", 32'(strobes), 32'd0);
    checkOutput("reset_flags", {29'd0, flagCarry, halted, busError}, 32'd0);
    #2;
    resetBar = 1'b1;
  endtask

  // RAM<-RAM with memReady low for low_cycles cycles from EXEC; called while in FETCH
  task automatic ramAccess(input int low_cycles, input string tag);
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k <= low_cycles; k++) begin
      memReady = (k == low_cycles);
      #1;
      checkOutput({tag, "_store"}, {31'd0, storeMem}, 32'd1);
      checkOutput({tag, "_assert"}, {24'd0, assertEn}, 32'h20);
      checkOutput({tag, "_load"}, {24'd0, loadEn}, (k == low_cycles) ? 32'h20 : 32'h00);
      tick();
    end
    checkOutput({tag, "_refetch"}, {31'd0, loadIR}, 32'd1);
    checkOutput({tag, "_no_error"}, {31'd0, busError}, 32'd0);
  endtask

  function automatic logic jumpRule(input logic hi, input logic lo, input logic az,
                                    input logic flag);
    return (lo && az) || (hi && flag) || (!lo && !hi);
  endfunction

  logic [7:0] r_ir;
  int         r_dest;
  int         r_src;
  int         r_delay;
  bit         r_ram;
  logic       model_flag;
  logic       r_az;
  logic       r_cy;
  logic [7:0] exp_load;
  logic       exp_jump;

  initial begin
    vecs[0]  = '{8'h22, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h2A, 1'b0, 1'b1, 8'h04, 8'h04, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'h90, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h90, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h18, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h18, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{8'h10, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'h05, 1'b0, 1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h53, 1'b0, 1'b0, 8'h20, 8'h08, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h37, 1'b0, 1'b0, 8'h08, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h98, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'h98, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{8'h62, 1'b0, 1'b0, 8'h40, 8'h04, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h2D, 1'b1, 1'b0, 8'h04, 8'h20, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'h58, 1'b0, 1'b0, 8'h20, 8'h01, 1'b1, 1'b0, 1'b1};

    resetBar = 1'b0;
    run      = 1'b0;
    ir       = 8'h00;
    memReady = 1'b0;
    aIsZero  = 1'b0;
    aluCarry = 1'b0;
`ifdef CONTROL_STEP_EN
    stepReq  = 1'b1;
`endif

    // Reset state
    #2;
    checkOutput("reset_strobes", 32'(strobes), 32'd0);
    checkOutput("reset_flags", {29'd0, flagCarry, halted, busError}, 32'd0);
    #5 resetBar = 1'b1;

    // IDLE holds with run low
    tick();
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_strobes", 32'(strobes), 32'd0);
    run = 1'b1;
    tick();

    // A<-A: FETCH then single EXEC cycle, carry latched
    checkOutput("t1_fetch_loadIR", {31'd0, loadIR}, 32'd1);
    checkOutput("t1_fetch_assert", {24'd0, assertEn}, 32'h01);
    tick();
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_exec_load", {24'd0, loadEn}, 32'h04);
    checkOutput("t1_exec_assert", {24'd0, assertEn}, 32'h04);
    checkOutput("t1_exec_loadIR", {31'd0, loadIR}, 32'd0);
    tick();
    checkOutput("t1_refetch", {31'd0, loadIR}, 32'd1);
    checkOutput("t1_flag", {31'd0, flagCarry}, 32'd1);

    // FETCH with run low returns to IDLE
    run = 1'b0;
    tick();
    checkOutput("fetch_to_idle", 32'(strobes), 32'd0);
    run = 1'b1;
    tick();

    // Table of single-cycle instructions, each preceded by a flag preload
    for (int i = 0; i < 15; i++) begin
      tick();
      applyStimulus(8'h22, 1'b1, 1'b0, vecs[i].carry);
      tick();
      checkOutput($sformatf("vec%0d_flag", i), {31'd0, flagCarry}, {31'd0, vecs[i].carry});
      tick();
      applyStimulus(vecs[i].ir, 1'b1, vecs[i].az, ~vecs[i].carry);
      checkOutput($sformatf("vec%0d_load", i), {24'd0, loadEn}, {24'd0, vecs[i].load_en});
      checkOutput($sformatf("vec%0d_assert", i), {24'd0, assertEn}, {24'd0, vecs[i].assert_en});
      checkOutput($sformatf("vec%0d_store", i), {31'd0, storeMem}, {31'd0, vecs[i].store});
      checkOutput($sformatf("vec%0d_jump", i), {31'd0, doJump}, {31'd0, vecs[i].jump});
      checkOutput($sformatf("vec%0d_sub", i), {31'd0, doSubtract}, {31'd0, vecs[i].sub});
      tick();
      checkOutput($sformatf("vec%0d_refetch", i), {31'd0, loadIR}, 32'd1);
    end

    // RAM access stretched by 3 cycles, and memReady on the last permitted WAIT cycle
    ramAccess(3, "ram3");
    ramAccess(16, "ram_last");

    // Randomized instructions against the instruction-level model
    model_flag = flagCarry;
    for (int n = 0; n < 80; n++) begin
      r_ir = 8'($urandom_range(0, 255));
      if (r_ir == 8'hFF) r_ir = 8'h7E;
      r_dest  = int'(r_ir[6:4]);
      r_src   = int'(r_ir[2:0]);
      r_ram   = (r_dest == 5) || (r_src == 5);
      r_delay = r_ram ? $urandom_range(0, 16) : 0;
      checkOutput("rnd_fetch", {31'd0, loadIR}, 32'd1);
      checkOutput("rnd_flag", {31'd0, flagCarry}, {31'd0, model_flag});
      applyStimulus(r_ir, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k <= r_delay; k++) begin
        r_az = 1'($urandom_range(0, 1));
        r_cy = 1'($urandom_range(0, 1));
        applyStimulus(r_ir, r_ram ? (k == r_delay) : 1'($urandom_range(0, 1)), r_az, r_cy);
        exp_load = 8'h00;
        exp_jump = 1'b0;
        if (k == r_delay) begin
          if (r_dest > 1) exp_load = 8'h01 << r_dest;
          if (r_dest == 1) exp_jump = jumpRule(r_ir[7], r_ir[3], r_az, model_flag);
        end
        checkOutput("rnd_assert", {24'd0, assertEn}, 32'h1 << r_src);
        checkOutput("rnd_store", {31'd0, storeMem}, {31'd0, r_dest == 5});
        checkOutput("rnd_sub", {31'd0, doSubtract}, {31'd0, r_ir[3]});
        checkOutput("rnd_load", {24'd0, loadEn}, {24'd0, exp_load});
        checkOutput("rnd_jump", {31'd0, doJump}, {31'd0, exp_jump});
        if (k == r_delay && r_dest == 2) model_flag = r_cy;
        tick();
      end
    end

    // Reset in the middle of WAIT drops storeMem without a clock edge
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    checkOutput("midwait_store", {31'd0, storeMem}, 32'd1);
    resetBar = 1'b0;
    #1;
    checkOutput("midwait_async_store", {31'd0, storeMem}, 32'd0);
    checkOutput("midwait_async_assert", {24'd0, assertEn}, 32'h00);
    #2 resetBar = 1'b1;
    tick();

    // memReady never arrives: timeout after WAIT_MAX+1 WAIT cycles
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("tmo_exec_store", {31'd0, storeMem}, 32'd1);
    tick();
    for (int w = 0; w < 16; w++) begin
      #1;
      checkOutput("tmo_wait_store", {31'd0, storeMem}, 32'd1);
      checkOutput("tmo_wait_load", {24'd0, loadEn}, 32'h00);
      checkOutput("tmo_wait_err", {31'd0, busError}, 32'd0);
      tick();
    end
    checkOutput("tmo_busError", {31'd0, busError}, 32'd1);
    checkOutput("tmo_halted", {31'd0, halted}, 32'd1);
    for (int w = 0; w < 3; w++) begin
      applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
      checkOutput("tmo_late_ready", 32'(strobes), 32'd0);
      checkOutput("tmo_sticky", {30'd0, halted, busError}, 32'd3);
      tick();
    end
    pulseReset();
    tick();

    // HALT opcode: sticky, no strobes, cleared only by reset
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("halt_pre_flag", {31'd0, flagCarry}, 32'd1);
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("halt_exec_strobes", {12'd0, loadIR, loadEn, assertEn, storeMem, doJump},
                32'd0);
    tick();
    for (int h = 0; h < 20; h++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      checkOutput("halt_strobes", 32'(strobes), 32'd0);
      checkOutput("halt_halted", {31'd0, halted}, 32'd1);
      tick();
    end
    run = 1'b0;
    pulseReset();
    tick();
    checkOutput("post_reset_idle", 32'(strobes), 32'd0);
    tick();
    checkOutput("post_reset_idle2", 32'(strobes), 32'd0);

`ifdef CONTROL_STEP_EN
    // Single-step: FETCH holds until a stepReq pulse, then exactly one EXEC
    stepReq = 1'b0;
    run     = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
      checkOutput("step_hold_loadIR", {31'd0, loadIR}, 32'd0);
      checkOutput("step_hold_load", {24'd0, loadEn}, 32'h00);
      tick();
    end
    stepReq = 1'b1;
    #1;
    checkOutput("step_fetch_loadIR", {31'd0, loadIR}, 32'd1);
    tick();
    stepReq = 1'b0;
    #1;
    checkOutput("step_exec_load", {24'd0, loadEn}, 32'h04);
    tick();
    checkOutput("step_after_loadIR", {31'd0, loadIR}, 32'd0);
    tick();
    checkOutput("step_no_second_exec", {24'd0, loadEn}, 32'h00);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
